// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Optional SEND watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [8*NUM_REQ-1:0]       Din_bus,
  output logic [NUM_REQ-1:0]         Ack,
  output logic                       Send,
  output logic [7:0]                 Dout,
  input  logic                       Sent,
  output logic                       Busy,
  output logic [$clog2(NUM_REQ)-1:0] Grant_id,
  output logic                       Err,
  output logic [1:0]                 State_dbg
);

  // Handshakes: requester i holds Req[i] and its byte until a one-cycle Ack[i];
  // toward the transmitter, Send rises with Dout frozen, falls after Sent rises,
  // and the byte completes only once Sent has fallen again (four-phase).

  localparam int idW  = $clog2(NUM_REQ);
  localparam int gapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} stateT;

  stateT           state;
  logic [idW-1:0]  ptr;
  logic [gapW-1:0] gapCnt;
  logic [7:0]      din [NUM_REQ];
  logic [idW-1:0]  winner;
  logic [idW-1:0]  cand;
  logic            anyReq;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign din[g] = Din_bus[8*g +: 8];
  end

  // First set request above the pointer, wrapping, so the last winner goes last.
  always_comb begin
    anyReq = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = idW'((int'(ptr) + k) % NUM_REQ);
      if (!anyReq && Req[cand]) begin
        anyReq = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int toW = $clog2(TIMEOUT_CYCLES + 1);
  logic [toW-1:0] toCnt;
  logic           timedOut;
  logic           errReg;
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Send     <= 1'b0;
      Dout     <= '0;
      Ack      <= '0;
      Grant_id <= '0;
      ptr      <= idW'(NUM_REQ - 1);
      gapCnt   <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      toCnt    <= '0;
      timedOut <= 1'b0;
      errReg   <= 1'b0;
`endif
    end else begin
      Ack <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      errReg <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (anyReq) begin
            Dout     <= din[winner];
            Grant_id <= winner;
            ptr      <= winner;
            Send     <= 1'b1;
            state    <= SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            toCnt    <= '0;
            timedOut <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (Sent) begin
            Send  <= 1'b0;
            state <= RELEASE;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (toCnt == toW'(TIMEOUT_CYCLES - 1)) begin
            Send     <= 1'b0;
            errReg   <= 1'b1;
            timedOut <= 1'b1;
            state    <= RELEASE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!Sent) begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
            if (!timedOut) Ack[Grant_id] <= 1'b1;
`else
            Ack[Grant_id] <= 1'b1;
`endif
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gapCnt <= gapW'(GAP_CYCLES - 1);
              state  <= GAP;
            end
          end
        end
        GAP: begin
          if (gapCnt == '0) state <= IDLE;
          else gapCnt <= gapCnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign Err = errReg;
`else
  assign Err = 1'b0;
`endif

  assign Busy      = (state != IDLE);
  assign State_dbg = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: transmitter model, grant/ack scoreboards, summary.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int GAP_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int W              = 10;

  logic                     clk = 1'b0;
  logic                     Reset_n = 1'b0;
  logic [NUM_REQ-1:0]       Req = '0;
  logic [8*NUM_REQ-1:0]     Din_bus = '0;
  logic [NUM_REQ-1:0]       Ack;
  logic                     Send;
  logic [7:0]               Dout;
  logic                     Sent = 1'b0;
  logic                     Busy;
  logic [1:0]               Grant_id;
  logic                     Err;
  logic [1:0]               State_dbg;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .Req(Req), .Din_bus(Din_bus), .Ack(Ack),
    .Send(Send), .Dout(Dout), .Sent(Sent), .Busy(Busy), .Grant_id(Grant_id),
    .Err(Err), .State_dbg(State_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_ack_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, ack_cyc = 0, send_start = 0, last_send_len = 0, err_pulses = 0;
  bit send_prev = 0, busy_prev = 0, sent_prev = 0;
  bit gap_armed = 0, busy_armed = 0, tight_gap = 0, dout_moved = 0;
  logic [7:0] held_dout = '0;
  int acks_per_id[NUM_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  int  sent_delay = 50, sent_hold = 2, tcnt = 0, hcnt = 0;
  bit  never_sent = 0;

  always @(posedge clk) begin
    #2;
    if (!Reset_n) begin
      Sent = 1'b0; tcnt = 0; hcnt = 0;
    end else if (Sent) begin
      hcnt++;
      if (hcnt >= sent_hold && !Send) begin Sent = 1'b0; tcnt = 0; end
    end else if (Send) begin
      tcnt++;
      if (!never_sent && tcnt >= sent_delay) begin Sent = 1'b1; hcnt = 0; end
    end else begin
      tcnt = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e_val;
    logic [1:0]   e_id;
    cyc++;
    if (!Reset_n) begin
      send_prev = 0; busy_prev = 0; sent_prev = 0; gap_armed = 0; busy_armed = 0;
    end else begin
      if (Send && !send_prev) begin
        check("grant_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_val = exp_q.pop_front();
          check("grant_id", Grant_id, e_val[9:8]);
          check("grant_dout", Dout, e_val[7:0]);
        end
        if (gap_armed) begin
          if (tight_gap) check("gap_exact", cyc - ack_cyc, GAP_CYCLES + 1);
          else           check("gap_min", (cyc - ack_cyc) >= GAP_CYCLES + 1, 1);
          gap_armed = 0;
        end
        held_dout = Dout; dout_moved = 0; send_start = cyc;
      end
      if (Send && send_prev && Dout !== held_dout) dout_moved = 1;
      if (!Send && send_prev) begin
        check("dout_frozen", dout_moved, 0);
        last_send_len = cyc - send_start;
      end
      if (Sent && sent_prev) check("send_low_while_sent", Send, 0);
      if (Ack != 0) begin
        check("ack_onehot", $countones(Ack), 1);
        check("ack_not_with_send", Send, 0);
        check("ack_after_sent_low", Sent, 0);
        check("ack_pending", exp_ack_q.size() != 0, 1);
        if (exp_ack_q.size() != 0) begin
          e_id = exp_ack_q.pop_front();
          check("ack_id", Ack, 4'(1) << e_id);
        end
        for (int i = 0; i < NUM_REQ; i++) if (Ack[i]) acks_per_id[i]++;
        ack_cyc = cyc; gap_armed = 1; busy_armed = 1;
      end
      if (!Busy && busy_prev && busy_armed) begin
        check("busy_after_gap", cyc - ack_cyc, GAP_CYCLES);
        busy_armed = 0;
      end
      if (Err) err_pulses++;
      send_prev = Send; busy_prev = Busy; sent_prev = Sent;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    Reset_n = 1'b0;
    repeat (n) @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic wait_acks(input int n, input logic [NUM_REQ-1:0] drop_mask, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clk); t++;
      if (Ack != 0) begin
        seen++;
        Req = Req & ~(Ack & drop_mask);
      end
    end
    check("acks_within_budget", seen, n);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    do begin @(negedge clk); t++; end while (Busy && t < budget);
    check("idle_within_budget", Busy, 0);
  endtask

  task automatic wait_level(input string name, input bit want_sent, input int budget);
    int t = 0;
    while ((want_sent ? Sent : Send) !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    check(name, want_sent ? Sent : Send, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_send", Send, 0);
    check("rst_dout", Dout, 0);
    check("rst_ack", Ack, 0);
    check("rst_busy", Busy, 0);
    check("rst_grant_id", Grant_id, 0);
    check("rst_err", Err, 0);
    check("rst_state", State_dbg, 0);
    Reset_n = 1'b1;

    // Simultaneous requests 0,1,3 from reset: rotation 0 -> 1 -> 3.
    Din_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd1, 8'h22}); exp_q.push_back({2'd3, 8'h44});
    exp_ack_q.push_back(2'd0); exp_ack_q.push_back(2'd1); exp_ack_q.push_back(2'd3);
    tight_gap = 1;
    Req = 4'b1011;
    wait_acks(3, 4'b1111, 2000);
    tight_gap = 0;
    wait_idle(100);

    // Single requester 2, byte 0xA5.
    Din_bus[23:16] = 8'hA5;
    exp_q.push_back({2'd2, 8'hA5}); exp_ack_q.push_back(2'd2);
    Req = 4'b0100;
    @(negedge clk);
    check("send_next_cycle", Send, 1);
    check("single_dout", Dout, 8'hA5);
    wait_acks(1, 4'b0100, 500);
    wait_idle(100);

    // Fairness: all held for 8 bytes after a fresh reset.
    do_reset(2);
    Din_bus = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_q.push_back({2'(i), Din_bus[8*i +: 8]});
        exp_ack_q.push_back(2'(i));
      end
    foreach (acks_per_id[i]) acks_per_id[i] = 0;
    tight_gap = 1;
    Req = '1;
    wait_acks(8, 4'b0000, 3000);
    Req = '0;
    tight_gap = 0;
    wait_idle(100);
    for (int i = 0; i < NUM_REQ; i++) check("fair_two_acks", acks_per_id[i], 2);

    // Long Sent: no Ack while Sent high; requester 2 arriving in the gap waits for it.
    sent_hold = 20;
    Din_bus[7:0] = 8'h5A; Din_bus[23:16] = 8'h6B;
    exp_q.push_back({2'd0, 8'h5A}); exp_ack_q.push_back(2'd0);
    exp_q.push_back({2'd2, 8'h6B}); exp_ack_q.push_back(2'd2);
    Req = 4'b0001;
    wait_level("sent_rises", 1'b1, 200);
    begin
      int t = 0;
      while (Sent && t < 100) begin check("no_ack_while_sent", Ack, 0); @(negedge clk); t++; end
    end
    wait_acks(1, 4'b0001, 100);
    tight_gap = 1;
    Req[2] = 1'b1;
    wait_acks(1, 4'b0100, 500);
    tight_gap = 0;
    sent_hold = 2;
    wait_idle(100);

    // Reset mid-SEND: pointer returns to NUM_REQ-1, so requester 1 beats 3.
    Din_bus[15:8] = 8'h3C; Din_bus[31:24] = 8'h4D;
    exp_q.push_back({2'd1, 8'h3C});
    Req = 4'b0010;
    wait_level("send_rises", 1'b0, 50);
    repeat (10) @(negedge clk);
    Req[3] = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("async_send_drop", Send, 0);
    check("async_busy_drop", Busy, 0);
    check("async_no_ack", Ack, 0);
    repeat (3) @(negedge clk);
    exp_q.push_back({2'd1, 8'h3C}); exp_q.push_back({2'd3, 8'h4D});
    exp_ack_q.push_back(2'd1); exp_ack_q.push_back(2'd3);
    Reset_n = 1'b1;
    wait_acks(2, 4'b1010, 1000);
    wait_idle(100);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Transmitter never answers requester 0; requester 2 is served after the gap.
    never_sent = 1;
    Din_bus[7:0] = 8'h88; Din_bus[23:16] = 8'h77;
    exp_q.push_back({2'd0, 8'h88}); exp_q.push_back({2'd2, 8'h77});
    exp_ack_q.push_back(2'd2);
    Req = 4'b0101;
    begin
      int t = 0;
      while (!Err && t < 300) begin @(negedge clk); t++; end
    end
    check("err_raised", Err, 1);
    check("err_grant_id", Grant_id, 0);
    Req[0] = 1'b0;
    never_sent = 0;
    @(negedge clk);
    check("timeout_send_len", last_send_len, TIMEOUT_CYCLES);
    check("err_one_cycle", Err, 0);
    check("timeout_no_ack", Ack, 0);
    wait_acks(1, 4'b0100, 500);
    wait_idle(100);
    check("err_pulse_count", err_pulses, 1);
`else
    check("err_tied_low", err_pulses, 0);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_ack_q_drained", exp_ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
